// File: rtl/matmul_xcel_row_feeder_ws_li.sv
// Row feeder for the weight-stationary PE array.
// It drives the left message input of PE column 0 for one systolic row with
// packed {data, is_weight} messages: NUM_PES weights, then the job's
// activations. All three inputs are latency-insensitive val/rdy streams.
// Every outgoing message passes through a 2-entry queue, so o_msg_send has no
// combinational path from any input.
// Optional build macro: MATMUL_XCEL_ROW_FEEDER_ZERO_PAD_EN. When it is defined,
// NUM_PES-1 zero activations follow each job to flush the row skew.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a job config (cfg rdy high)
// LOAD_W | forwarding NUM_PES weights from i_wt_recv
// STREAM | forwarding num_acts activations from i_act_recv
// PAD    | injecting NUM_PES-1 zero activations (macro builds only)
// DRAIN  | no new messages; waiting for the output queue to empty
// DONE   | one-cycle o_done pulse, then back to IDLE
module matmul_xcel_row_feeder_ws_li #(
   parameter int BIT_WIDTH = 8,
   parameter int NUM_PES   = 4,
   parameter int MAX_ACTS  = 16,
   localparam int CW       = $clog2(MAX_ACTS + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [CW:0]          i_cfg_recv,
   input  logic                 i_cfg_recv_val,
   output logic                 o_cfg_recv_rdy,
   input  logic [BIT_WIDTH-1:0] i_wt_recv,
   input  logic                 i_wt_recv_val,
   output logic                 o_wt_recv_rdy,
   input  logic [BIT_WIDTH-1:0] i_act_recv,
   input  logic                 i_act_recv_val,
   output logic                 o_act_recv_rdy,
   output logic [BIT_WIDTH:0]   o_msg_send,
   output logic                 o_msg_send_val,
   input  logic                 i_msg_send_rdy,
   output logic                 o_done
);

   localparam int MW = BIT_WIDTH + 1;
   localparam int WW = (NUM_PES > 1) ? $clog2(NUM_PES) : 1;
   localparam logic [WW-1:0] W_LAST  = WW'(NUM_PES - 1);
   localparam logic [CW-1:0] ACT_MAX = CW'(MAX_ACTS);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD_W = 3'd1,
      S_STREAM = 3'd2,
      S_DRAIN  = 3'd3,
`ifdef MATMUL_XCEL_ROW_FEEDER_ZERO_PAD_EN
      S_PAD    = 3'd5,
`endif
      S_DONE   = 3'd4
   } state_t;

   // Where the FSM goes once the real activations are exhausted.
`ifdef MATMUL_XCEL_ROW_FEEDER_ZERO_PAD_EN
   localparam state_t S_POST = S_PAD;
   localparam logic [WW-1:0] P_LAST = WW'(NUM_PES - 2);
   logic [WW-1:0] pcnt;
`else
   localparam state_t S_POST = S_DRAIN;
`endif

   state_t state, state_nxt;

   logic [CW-1:0] cfg_num_raw, cfg_num;
   logic          cfg_load, cfg_fire;
   logic [CW-1:0] num_acts_r, acnt, act_last;
   logic [WW-1:0] wcnt;

   logic          enq_val, enq_fire;
   logic [MW-1:0] enq_msg;
   logic          q_rdy, q_deq;
   logic [MW-1:0] q_mem [2];
   logic          q_head, q_tail;
   logic [1:0]    q_cnt;

   // Oversized job lengths are clamped rather than rejected.
   assign cfg_num_raw = i_cfg_recv[CW:1];
   assign cfg_load    = i_cfg_recv[0];
   assign cfg_num     = (cfg_num_raw > ACT_MAX) ? ACT_MAX : cfg_num_raw;
   assign cfg_fire    = i_cfg_recv_val && o_cfg_recv_rdy;
   assign act_last    = num_acts_r - CW'(1);

   assign q_rdy          = (q_cnt != 2'd2);
   assign o_msg_send_val = (q_cnt != 2'd0);
   assign o_msg_send     = q_mem[q_head];
   assign q_deq          = o_msg_send_val && i_msg_send_rdy;
   assign enq_fire       = enq_val && q_rdy;

   // Queue storage; contents are don't-care while the entry is empty.
   always_ff @(posedge clk) begin
      if (enq_fire) q_mem[q_tail] <= enq_msg;
   end

   // Queue pointers and occupancy; reset discards anything buffered.
   always_ff @(posedge clk) begin
      if (reset) begin
         q_head <= 1'b0;
         q_tail <= 1'b0;
         q_cnt  <= 2'd0;
      end else begin
         if (enq_fire) q_tail <= ~q_tail;
         if (q_deq)    q_head <= ~q_head;
         case ({enq_fire, q_deq})
            2'b10:   q_cnt <= q_cnt + 2'd1;
            2'b01:   q_cnt <= q_cnt - 2'd1;
            default: q_cnt <= q_cnt;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (cfg_fire) begin
               if (cfg_load)              state_nxt = S_LOAD_W;
               else if (cfg_num != '0)    state_nxt = S_STREAM;
               else                       state_nxt = S_POST;
            end
         end
         S_LOAD_W: begin
            if (enq_fire && wcnt == W_LAST)
               state_nxt = (num_acts_r != '0) ? S_STREAM : S_POST;
         end
         S_STREAM: begin
            if (enq_fire && acnt == act_last) state_nxt = S_POST;
         end
`ifdef MATMUL_XCEL_ROW_FEEDER_ZERO_PAD_EN
         S_PAD: begin
            if (enq_fire && pcnt == P_LAST) state_nxt = S_DRAIN;
         end
`endif
         // Leave as soon as the last queued message is leaving, so o_done
         // lands the cycle right after the final send.
         S_DRAIN: begin
            if (q_cnt == 2'd0 || (q_cnt == 2'd1 && q_deq)) state_nxt = S_DONE;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output and enqueue-source decode; input rdys depend only on state and queue space.
   always_comb begin
      o_cfg_recv_rdy = 1'b0;
      o_wt_recv_rdy  = 1'b0;
      o_act_recv_rdy = 1'b0;
      o_done         = 1'b0;
      enq_val        = 1'b0;
      enq_msg        = '0;
      case (state)
         S_IDLE:   o_cfg_recv_rdy = 1'b1;
         S_LOAD_W: begin
            o_wt_recv_rdy = q_rdy;
            enq_val       = i_wt_recv_val;
            enq_msg       = {i_wt_recv, 1'b1};
         end
         S_STREAM: begin
            o_act_recv_rdy = q_rdy;
            enq_val        = i_act_recv_val;
            enq_msg        = {i_act_recv, 1'b0};
         end
`ifdef MATMUL_XCEL_ROW_FEEDER_ZERO_PAD_EN
         S_PAD: begin
            enq_val = 1'b1;
            enq_msg = '0;
         end
`endif
         S_DONE:   o_done = 1'b1;
         default:  ;
      endcase
   end

   // Job length latch and per-phase message counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         num_acts_r <= '0;
         wcnt       <= '0;
         acnt       <= '0;
`ifdef MATMUL_XCEL_ROW_FEEDER_ZERO_PAD_EN
         pcnt       <= '0;
`endif
      end else begin
         if (cfg_fire) num_acts_r <= cfg_num;
         if (state == S_LOAD_W && enq_fire)
            wcnt <= (wcnt == W_LAST) ? '0 : wcnt + WW'(1);
         if (state == S_STREAM && enq_fire)
            acnt <= (acnt == act_last) ? '0 : acnt + CW'(1);
`ifdef MATMUL_XCEL_ROW_FEEDER_ZERO_PAD_EN
         if (state == S_PAD && enq_fire)
            pcnt <= (pcnt == P_LAST) ? '0 : pcnt + WW'(1);
`endif
      end
   end

endmodule

// File: tb/tb_matmul_xcel_row_feeder_ws_li.sv
// Directed bench for the weight-stationary row feeder.
module tb_matmul_xcel_row_feeder_ws_li;
   localparam int BW = 8;
   localparam int NP = 4;
   localparam int MA = 16;
   localparam int CW = $clog2(MA + 1);
`ifdef MATMUL_XCEL_ROW_FEEDER_ZERO_PAD_EN
   localparam int PAD_N = NP - 1;
`else
   localparam int PAD_N = 0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [CW:0]   i_cfg_recv = '0;
   logic          i_cfg_recv_val = 1'b0;
   logic          o_cfg_recv_rdy;
   logic [BW-1:0] i_wt_recv = '0;
   logic          i_wt_recv_val = 1'b0;
   logic          o_wt_recv_rdy;
   logic [BW-1:0] i_act_recv = '0;
   logic          i_act_recv_val = 1'b0;
   logic          o_act_recv_rdy;
   logic [BW:0]   o_msg_send;
   logic          o_msg_send_val;
   logic          i_msg_send_rdy = 1'b1;
   logic          o_done;

   int tot = 0;
   int bad = 0;

   logic [BW:0] sent_q[$];
   int cyc = 0, last_send_cyc = 0, done_cyc = 0;
   int done_cnt = 0, wt_fires = 0, occ = 0, max_occ = 0;

   matmul_xcel_row_feeder_ws_li #(.BIT_WIDTH(BW), .NUM_PES(NP), .MAX_ACTS(MA)) dut (
      .clk(clk), .reset(reset),
      .i_cfg_recv(i_cfg_recv), .i_cfg_recv_val(i_cfg_recv_val), .o_cfg_recv_rdy(o_cfg_recv_rdy),
      .i_wt_recv(i_wt_recv), .i_wt_recv_val(i_wt_recv_val), .o_wt_recv_rdy(o_wt_recv_rdy),
      .i_act_recv(i_act_recv), .i_act_recv_val(i_act_recv_val), .o_act_recv_rdy(o_act_recv_rdy),
      .o_msg_send(o_msg_send), .o_msg_send_val(o_msg_send_val), .i_msg_send_rdy(i_msg_send_rdy),
      .o_done(o_done)
   );

   always #5 clk = ~clk;

   // Observe handshakes at the clock edge where they complete.
   always @(posedge clk) begin
      int d;
      d = 0;
      cyc <= cyc + 1;
      if (reset) begin
         occ     <= 0;
         max_occ <= 0;
      end else begin
         if (o_msg_send_val && i_msg_send_rdy) begin
            sent_q.push_back(o_msg_send);
            last_send_cyc <= cyc;
            d = d - 1;
         end
         if (i_wt_recv_val && o_wt_recv_rdy) begin
            wt_fires <= wt_fires + 1;
            d = d + 1;
         end
         if (i_act_recv_val && o_act_recv_rdy) d = d + 1;
         if (o_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
         end
         occ <= occ + d;
         if (occ + d > max_occ) max_occ <= occ + d;
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      i_cfg_recv_val = 1'b0;
      i_wt_recv_val  = 1'b0;
      i_act_recv_val = 1'b0;
      i_msg_send_rdy = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic send_cfg(input int n, input bit ld);
      int k = 0;
      bit fired = 1'b0;
      i_cfg_recv = {n[CW-1:0], ld};
      i_cfg_recv_val = 1'b1;
      while (!fired && k < 200) begin
         @(negedge clk);
         fired = o_cfg_recv_rdy;
         @(posedge clk);
         #1;
         k++;
      end
      i_cfg_recv_val = 1'b0;
      if (!fired) begin
         bad++;
         $display("FAIL cfg_accept: cfg not taken after %0d cycles, required acceptance", k);
      end
   endtask

   task automatic push(input bit is_act, input logic [BW-1:0] d);
      int k = 0;
      bit fired = 1'b0;
      if (is_act) begin i_act_recv = d; i_act_recv_val = 1'b1; end
      else        begin i_wt_recv  = d; i_wt_recv_val  = 1'b1; end
      while (!fired && k < 200) begin
         @(negedge clk);
         fired = is_act ? o_act_recv_rdy : o_wt_recv_rdy;
         @(posedge clk);
         #1;
         k++;
      end
      if (is_act) i_act_recv_val = 1'b0;
      else        i_wt_recv_val  = 1'b0;
      if (!fired) begin
         bad++;
         $display("FAIL push_accept: %s 0x%0h not taken, required acceptance", is_act ? "act" : "wt", d);
      end
   endtask

   task automatic wait_done(input int start);
      int k = 0;
      while (done_cnt == start && k < 400) begin
         @(posedge clk);
         #1;
         k++;
      end
      tot++;
      if (done_cnt == start) begin
         bad++;
         $display("FAIL done_wait: o_done count %0d, required %0d", done_cnt - start, 1);
      end
   endtask

   task automatic test_reset();
      do_reset();
      tot++; if (o_msg_send_val !== 1'b0) begin bad++; $display("FAIL rst_val: got %b want 0", o_msg_send_val); end
      tot++; if (o_done !== 1'b0)         begin bad++; $display("FAIL rst_done: got %b want 0", o_done); end
      tot++; if (o_cfg_recv_rdy !== 1'b1) begin bad++; $display("FAIL rst_cfg_rdy: got %b want 1", o_cfg_recv_rdy); end
      tot++; if (o_wt_recv_rdy !== 1'b0)  begin bad++; $display("FAIL rst_wt_rdy: got %b want 0", o_wt_recv_rdy); end
      tot++; if (o_act_recv_rdy !== 1'b0) begin bad++; $display("FAIL rst_act_rdy: got %b want 0", o_act_recv_rdy); end
   endtask

   task automatic test_weight_load();
      logic [BW:0] exp[$];
      int base, d0;
      exp = '{9'h007, 9'h00B, 9'h00F, 9'h013};
      for (int i = 0; i < PAD_N; i++) exp.push_back('0);
      base = sent_q.size();
      d0 = done_cnt;
      send_cfg(0, 1'b1);
      push(1'b0, 8'd3); push(1'b0, 8'd5); push(1'b0, 8'd7); push(1'b0, 8'd9);
      wait_done(d0);
      tot++;
      if (sent_q.size() - base != exp.size()) begin
         bad++; $display("FAIL wl_count: got %0d msgs want %0d", sent_q.size() - base, exp.size());
      end
      for (int i = 0; i < exp.size(); i++) begin
         tot++;
         if (base + i >= sent_q.size() || sent_q[base + i] !== exp[i]) begin
            bad++; $display("FAIL wl_msg%0d: got 0x%0h want 0x%0h", i,
                            (base + i < sent_q.size()) ? sent_q[base + i] : 9'h1FF, exp[i]);
         end
      end
      tot++;
      if (done_cyc - last_send_cyc != 1) begin
         bad++; $display("FAIL wl_done_lat: got %0d cycles want 1", done_cyc - last_send_cyc);
      end
      tot++; if (o_cfg_recv_rdy !== 1'b1) begin bad++; $display("FAIL wl_idle: cfg_rdy %b want 1", o_cfg_recv_rdy); end
   endtask

   task automatic test_full_job();
      logic [BW:0] exp[$];
      int base, d0;
      exp = '{9'h003, 9'h005, 9'h007, 9'h009, 9'h014, 9'h028, 9'h03C};
      for (int i = 0; i < PAD_N; i++) exp.push_back('0);
      base = sent_q.size();
      d0 = done_cnt;
      send_cfg(3, 1'b1);
      push(1'b0, 8'd1); push(1'b0, 8'd2); push(1'b0, 8'd3); push(1'b0, 8'd4);
      push(1'b1, 8'd10); push(1'b1, 8'd20); push(1'b1, 8'd30);
      wait_done(d0);
      repeat (5) @(posedge clk);
      #1;
      tot++;
      if (sent_q.size() - base != exp.size()) begin
         bad++; $display("FAIL fj_count: got %0d msgs want %0d", sent_q.size() - base, exp.size());
      end
      for (int i = 0; i < exp.size(); i++) begin
         tot++;
         if (base + i >= sent_q.size() || sent_q[base + i] !== exp[i]) begin
            bad++; $display("FAIL fj_msg%0d: got 0x%0h want 0x%0h", i,
                            (base + i < sent_q.size()) ? sent_q[base + i] : 9'h1FF, exp[i]);
         end
      end
      tot++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL fj_done_pulses: got %0d want 1", done_cnt - d0); end
   endtask

   task automatic test_reuse();
      logic [BW:0] exp[$];
      int base, d0, w0;
      exp = '{9'h00C, 9'h010};
      for (int i = 0; i < PAD_N; i++) exp.push_back('0);
      base = sent_q.size();
      d0 = done_cnt;
      w0 = wt_fires;
      i_wt_recv = 8'hFF;
      i_wt_recv_val = 1'b1;
      send_cfg(2, 1'b0);
      push(1'b1, 8'd6); push(1'b1, 8'd8);
      wait_done(d0);
      i_wt_recv_val = 1'b0;
      tot++;
      if (sent_q.size() - base != exp.size()) begin
         bad++; $display("FAIL ru_count: got %0d msgs want %0d", sent_q.size() - base, exp.size());
      end
      for (int i = 0; i < exp.size(); i++) begin
         tot++;
         if (base + i >= sent_q.size() || sent_q[base + i] !== exp[i]) begin
            bad++; $display("FAIL ru_msg%0d: got 0x%0h want 0x%0h", i,
                            (base + i < sent_q.size()) ? sent_q[base + i] : 9'h1FF, exp[i]);
         end
      end
      tot++; if (wt_fires != w0) begin bad++; $display("FAIL ru_wt_taken: got %0d weights want 0", wt_fires - w0); end
   endtask

   task automatic test_backpressure();
      logic [BW:0] exp[$];
      int base, d0;
      do_reset();
      for (int i = 1; i <= 8; i++) exp.push_back({8'(i * 11), 1'b0});
      for (int i = 0; i < PAD_N; i++) exp.push_back('0);
      base = sent_q.size();
      d0 = done_cnt;
      send_cfg(8, 1'b0);
      fork
         begin
            for (int i = 1; i <= 8; i++) push(1'b1, 8'(i * 11));
         end
         begin
            for (int c = 0; c < 40; c++) begin
               if (c >= 3 && c < 13) i_msg_send_rdy = 1'b0;
               else                  i_msg_send_rdy = 1'($urandom_range(0, 1));
               @(negedge clk);
               if (c == 12) begin
                  tot++; if (occ != 2) begin bad++; $display("FAIL bp_full: occupancy %0d want 2", occ); end
                  tot++; if (o_act_recv_rdy !== 1'b0) begin bad++; $display("FAIL bp_act_rdy: got %b want 0", o_act_recv_rdy); end
                  tot++; if (o_msg_send_val !== 1'b1) begin bad++; $display("FAIL bp_val: got %b want 1", o_msg_send_val); end
               end
               @(posedge clk);
               #1;
            end
            i_msg_send_rdy = 1'b1;
         end
      join
      wait_done(d0);
      tot++; if (max_occ > 2) begin bad++; $display("FAIL bp_max_occ: got %0d want <=2", max_occ); end
      tot++;
      if (sent_q.size() - base != exp.size()) begin
         bad++; $display("FAIL bp_count: got %0d msgs want %0d", sent_q.size() - base, exp.size());
      end
      for (int i = 0; i < exp.size(); i++) begin
         tot++;
         if (base + i >= sent_q.size() || sent_q[base + i] !== exp[i]) begin
            bad++; $display("FAIL bp_msg%0d: got 0x%0h want 0x%0h", i,
                            (base + i < sent_q.size()) ? sent_q[base + i] : 9'h1FF, exp[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [BW:0] exp[$];
      int base, d0;
      do_reset();
      i_msg_send_rdy = 1'b0;
      d0 = done_cnt;
      send_cfg(3, 1'b0);
      push(1'b1, 8'd5);
      tot++; if (o_msg_send_val !== 1'b1) begin bad++; $display("FAIL rm_pre_val: got %b want 1", o_msg_send_val); end
      reset = 1'b1;
      @(posedge clk);
      #1;
      tot++; if (o_msg_send_val !== 1'b0) begin bad++; $display("FAIL rm_val: got %b want 0", o_msg_send_val); end
      tot++; if (o_cfg_recv_rdy !== 1'b1) begin bad++; $display("FAIL rm_cfg_rdy: got %b want 1", o_cfg_recv_rdy); end
      tot++; if (o_act_recv_rdy !== 1'b0) begin bad++; $display("FAIL rm_act_rdy: got %b want 0", o_act_recv_rdy); end
      reset = 1'b0;
      i_msg_send_rdy = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      tot++; if (done_cnt != d0) begin bad++; $display("FAIL rm_no_done: got %0d pulses want 0", done_cnt - d0); end
      exp = '{9'h0AA};
      for (int i = 0; i < PAD_N; i++) exp.push_back('0);
      base = sent_q.size();
      send_cfg(1, 1'b0);
      push(1'b1, 8'h55);
      wait_done(d0);
      tot++;
      if (sent_q.size() - base != exp.size()) begin
         bad++; $display("FAIL rm_count: got %0d msgs want %0d", sent_q.size() - base, exp.size());
      end
      for (int i = 0; i < exp.size(); i++) begin
         tot++;
         if (base + i >= sent_q.size() || sent_q[base + i] !== exp[i]) begin
            bad++; $display("FAIL rm_msg%0d: got 0x%0h want 0x%0h", i,
                            (base + i < sent_q.size()) ? sent_q[base + i] : 9'h1FF, exp[i]);
         end
      end
   endtask

   task automatic test_zero_pad();
      logic [BW:0] exp[$];
      int base, d0;
      exp = '{9'h002, 9'h004};
      for (int i = 0; i < PAD_N; i++) exp.push_back('0);
      base = sent_q.size();
      d0 = done_cnt;
      send_cfg(2, 1'b0);
      push(1'b1, 8'd1); push(1'b1, 8'd2);
      wait_done(d0);
      tot++;
      if (sent_q.size() - base != exp.size()) begin
         bad++; $display("FAIL zp_count: got %0d msgs want %0d", sent_q.size() - base, exp.size());
      end
      for (int i = 0; i < exp.size(); i++) begin
         tot++;
         if (base + i >= sent_q.size() || sent_q[base + i] !== exp[i]) begin
            bad++; $display("FAIL zp_msg%0d: got 0x%0h want 0x%0h", i,
                            (base + i < sent_q.size()) ? sent_q[base + i] : 9'h1FF, exp[i]);
         end
      end
   endtask

   task automatic test_empty_job();
      int base, d0;
      base = sent_q.size();
      d0 = done_cnt;
      send_cfg(0, 1'b0);
      wait_done(d0);
      tot++;
      if (sent_q.size() - base != PAD_N) begin
         bad++; $display("FAIL ej_count: got %0d msgs want %0d", sent_q.size() - base, PAD_N);
      end
   endtask

   task automatic test_saturate();
      logic [BW:0] exp[$];
      int base, d0;
      for (int i = 0; i < MA; i++) exp.push_back({8'(i + 100), 1'b0});
      for (int i = 0; i < PAD_N; i++) exp.push_back('0);
      base = sent_q.size();
      d0 = done_cnt;
      send_cfg(20, 1'b0);
      for (int i = 0; i < MA; i++) push(1'b1, 8'(i + 100));
      wait_done(d0);
      tot++; if (o_act_recv_rdy !== 1'b0) begin bad++; $display("FAIL sat_act_rdy: got %b want 0", o_act_recv_rdy); end
      tot++;
      if (sent_q.size() - base != exp.size()) begin
         bad++; $display("FAIL sat_count: got %0d msgs want %0d", sent_q.size() - base, exp.size());
      end
      for (int i = 0; i < exp.size(); i++) begin
         tot++;
         if (base + i >= sent_q.size() || sent_q[base + i] !== exp[i]) begin
            bad++; $display("FAIL sat_msg%0d: got 0x%0h want 0x%0h", i,
                            (base + i < sent_q.size()) ? sent_q[base + i] : 9'h1FF, exp[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_weight_load();
      test_full_job();
      test_reuse();
      test_backpressure();
      test_reset_mid();
      test_zero_pad();
      test_empty_job();
      test_saturate();
      $display("test done: total=%0d bad=%0d", tot, bad);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end
endmodule
